// File: rtl/tblink_rpc_invoke_arb_pkg.sv
// Shared types and helpers for the invoke arbiter: FSM states, id width
// helper and the round-robin pick function.
package tblink_rpc_arb_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned PICK_W  = 4;

    typedef enum logic {
        ARB   = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    // Width of a requester tag; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of mask at or after ptr, wrapping within the first n bits.
    function automatic logic [PICK_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] mask,
        input logic [PICK_W-1:0]  ptr,
        input int unsigned        n
    );
        logic [PICK_W-1:0] pick;
        logic              found;
        int unsigned       idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % n;
            if (!found && (k < n) && mask[idx[PICK_W-1:0]]) begin
                pick  = idx[PICK_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tblink_rpc_call_tracker.sv
// Per-requester outstanding-call tracker: pending bit plus a saturating
// age counter that expires the call once it reaches the timeout limit.
module tblink_rpc_call_tracker
    import tblink_rpc_arb_pkg::*;
#(
    parameter int unsigned TMO_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_i,
    input  logic             ret_i,
    input  logic [TMO_W-1:0] tmo_cycles_i,
    output logic             pending_o,
    output logic             ok_o,
    output logic             tmo_o
);

    logic             pending_q, pending_d;
    logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             expire;

    // Age/expiry evaluation; a return in the expiry cycle takes precedence.
    always_comb begin
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);
        expire    = pending_q && (tmo_cycles_i != '0) && (cnt_inc >= tmo_cycles_i);
        ok_o      = pending_q && ret_i;
        tmo_o     = expire && !ret_i;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        if (set_i) begin
            pending_d = 1'b1;
            cnt_d     = '0;
        end else if (pending_q) begin
            cnt_d = cnt_inc;
            if (ok_o || tmo_o) begin
                pending_d = 1'b0;
            end
        end
    end

    // Pending flag and age counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/tblink_rpc_invoke_arb.sv
// Round-robin arbiter sharing one endpoint invoke channel among N_REQ BFM
// requesters, with per-requester return routing and call timeouts.
module tblink_rpc_invoke_arb
    import tblink_rpc_arb_pkg::*;
#(
    parameter  int unsigned N_REQ    = 4,
    parameter  int unsigned METHOD_W = 8,
    parameter  int unsigned PARAM_W  = 64,
    parameter  int unsigned TMO_W    = 16,
    localparam int unsigned IDW      = id_width(N_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          req_blocking,
    input  logic [N_REQ*METHOD_W-1:0] req_method,
    input  logic [N_REQ*PARAM_W-1:0]  req_params,
    output logic                      inv_valid,
    input  logic                      inv_ready,
    output logic [IDW-1:0]            inv_id,
    output logic [METHOD_W-1:0]       inv_method,
    output logic [PARAM_W-1:0]        inv_params,
    output logic                      inv_blocking,
    input  logic                      ret_valid,
    input  logic [IDW-1:0]            ret_id,
    input  logic [PARAM_W-1:0]        ret_data,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [N_REQ-1:0]          rsp_err,
    output logic [PARAM_W-1:0]        rsp_data,
    input  logic [TMO_W-1:0]          tmo_cycles,
    output logic [N_REQ-1:0]          pending,
    output logic                      spurious
);

    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d, grant_idx;
    logic [PICK_W-1:0]   pick;
    logic [MAX_REQ-1:0]  elig_ext;
    logic [N_REQ-1:0]    eligible, ready_vec, set_vec, ret_vec, ok_vec, tmo_vec, pending_vec;

    logic [IDW-1:0]      inv_id_q, inv_id_d;
    logic [METHOD_W-1:0] inv_method_q, inv_method_d;
    logic [PARAM_W-1:0]  inv_params_q, inv_params_d;
    logic                inv_blocking_q, inv_blocking_d;

    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [PARAM_W-1:0]  rsp_data_q, rsp_data_d;
    logic                spurious_q, spurious_d;

    // Arbitration / issue FSM next-state and invoke latch.
    always_comb begin
        eligible  = req_valid & ~pending_vec;
        elig_ext  = '0;
        elig_ext[N_REQ-1:0] = eligible;
        pick      = rr_pick(elig_ext, PICK_W'(ptr_q), N_REQ);
        grant_idx = pick[IDW-1:0];

        state_d        = state_q;
        ptr_d          = ptr_q;
        ready_vec      = '0;
        set_vec        = '0;
        inv_id_d       = inv_id_q;
        inv_method_d   = inv_method_q;
        inv_params_d   = inv_params_q;
        inv_blocking_d = inv_blocking_q;

        case (state_q)
            ARB: begin
                if (|eligible) begin
                    ready_vec[grant_idx] = 1'b1;
                    inv_id_d       = grant_idx;
                    inv_method_d   = req_method[grant_idx*METHOD_W +: METHOD_W];
                    inv_params_d   = req_params[grant_idx*PARAM_W +: PARAM_W];
                    inv_blocking_d = req_blocking[grant_idx];
                    ptr_d          = (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + IDW'(1);
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (inv_ready) begin
                    set_vec[inv_id_q] = inv_blocking_q;
                    state_d           = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Per-requester trackers; a return id outside the requester range
    // matches no lane and therefore falls through to the spurious path.
    for (genvar i = 0; i < N_REQ; i++) begin : g_trk
        assign ret_vec[i] = ret_valid && (ret_id == IDW'(i));

        tblink_rpc_call_tracker #(
            .TMO_W(TMO_W)
        ) u_trk (
            .clk_i       (clock),
            .rst_i       (reset),
            .set_i       (set_vec[i]),
            .ret_i       (ret_vec[i]),
            .tmo_cycles_i(tmo_cycles),
            .pending_o   (pending_vec[i]),
            .ok_o        (ok_vec[i]),
            .tmo_o       (tmo_vec[i])
        );
    end

    // Response and spurious-return next values.
    always_comb begin
        rsp_valid_d = ok_vec | tmo_vec;
        rsp_err_d   = tmo_vec;
        rsp_data_d  = (|ok_vec) ? ret_data : '0;
        spurious_d  = ret_valid && !(|ok_vec);
    end

    // State, pointer, invoke and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ARB;
            ptr_q          <= '0;
            inv_id_q       <= '0;
            inv_method_q   <= '0;
            inv_params_q   <= '0;
            inv_blocking_q <= 1'b0;
            rsp_valid_q    <= '0;
            rsp_err_q      <= '0;
            rsp_data_q     <= '0;
            spurious_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            inv_id_q       <= inv_id_d;
            inv_method_q   <= inv_method_d;
            inv_params_q   <= inv_params_d;
            inv_blocking_q <= inv_blocking_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_err_q      <= rsp_err_d;
            rsp_data_q     <= rsp_data_d;
            spurious_q     <= spurious_d;
        end
    end

    // The grant is combinational, so it is masked while reset is held.
    assign req_ready    = reset ? '0 : ready_vec;
    assign inv_valid    = (state_q == ISSUE);
    assign inv_id       = inv_id_q;
    assign inv_method   = inv_method_q;
    assign inv_params   = inv_params_q;
    assign inv_blocking = inv_blocking_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_data     = rsp_data_q;
    assign spurious     = spurious_q;
    assign pending      = pending_vec;

endmodule
